psram_qpi_responder: RTL and testbench



---
 rtl/psram_pkg.sv | 23 ++
 rtl/psram_array.sv | 25 ++
 rtl/psram_qpi_responder.sv | 193 +++++++++++++++++++
 tb/tb_psram_qpi_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared constants and types for the PSRAM QPI responder model.
package psram_pkg;

  localparam logic [7:0] CMD_ENTER_QPI  = 8'h35;
  localparam logic [7:0] CMD_EXIT_QPI   = 8'hF5;
  localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
  localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;

  // Address field carried by every QPI read/write frame, sent one nibble per cycle.
  localparam int FRAME_ADDR_W  = 24;
  localparam int ADDR_NIBBLES  = FRAME_ADDR_W / 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/psram_array.sv
// Single-port byte RAM: synchronous write, registered read (read-first).
module psram_array #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 we,
  input  logic [7:0]           wdata,
  input  logic                 re,
  output logic [7:0]           rdata
);

  logic [7:0] mem [2**ADDR_BITS];

  // Write and read share one address; a same-cycle read returns the old byte.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/psram_qpi_responder.sv
// PSRAM device model: SPI/QPI command decode, quad read and quad write
// against a small internal byte array. WAIT_CYCLES must lie in 2..15.
module psram_qpi_responder
  import psram_pkg::*;
#(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic       sio_oe,
  output logic       qpi_mode
);

  localparam int CYC_W = 5;
  // Frame cycle numbers (counted in rising edges with cs_n low).
  localparam logic [CYC_W-1:0] CYC_SPI_CMD_LAST = CYC_W'(7);
  localparam logic [CYC_W-1:0] CYC_ADDR_LAST    = CYC_W'(1 + ADDR_NIBBLES);
  localparam logic [CYC_W-1:0] CYC_DATA0        = CYC_W'(2 + ADDR_NIBBLES);
  localparam logic [CYC_W-1:0] CYC_WAIT_LAST    = CYC_W'(2 + ADDR_NIBBLES + WAIT_CYCLES - 1);

  state_t               state;
  logic [CYC_W-1:0]     cyc;
  logic [6:0]           cmd_sr;
  logic [ADDR_BITS-1:0] addr;
  logic                 is_read;
  logic [3:0]           wr_hi;
  logic                 wr_hi_vld;
  logic                 hi_on_bus;
  logic                 oe_reg;
  logic                 pending_qpi;
  logic                 pending_exit;

  logic [ADDR_BITS-1:0] arr_addr;
  logic                 arr_we;
  logic                 arr_re;
  logic [7:0]           arr_wdata;
  logic [7:0]           arr_rdata;

  logic [7:0]           spi_cmd;
  logic [7:0]           qpi_cmd;

  assign spi_cmd = {cmd_sr, sio_in[0]};
  assign qpi_cmd = {cmd_sr[3:0], sio_in};
  assign sio_oe  = oe_reg & ~cs_n;

  // Array port control: the first read is issued at cycle 8; afterwards the next
  // byte is fetched while the current byte's high nibble is on the bus.
  always_comb begin
    arr_addr  = addr;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_wdata = {wr_hi, sio_in};
    if (!cs_n) begin
      if (state == ST_WAIT && cyc == CYC_DATA0) begin
        arr_re = 1'b1;
      end
      if (state == ST_RD_DATA && hi_on_bus) begin
        arr_addr = addr + ADDR_BITS'(1);
        arr_re   = 1'b1;
      end
      if (state == ST_WR_DATA && wr_hi_vld) begin
        arr_we = 1'b1;
      end
    end
  end

  psram_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .addr  (arr_addr),
    .we    (arr_we),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  // Frame FSM: cs_n high returns to IDLE and commits pending mode changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cyc          <= '0;
      cmd_sr       <= '0;
      addr         <= '0;
      is_read      <= 1'b0;
      wr_hi        <= '0;
      wr_hi_vld    <= 1'b0;
      hi_on_bus    <= 1'b0;
      oe_reg       <= 1'b0;
      sio_out      <= '0;
      qpi_mode     <= 1'b0;
      pending_qpi  <= 1'b0;
      pending_exit <= 1'b0;
    end else if (cs_n) begin
      state        <= ST_IDLE;
      cyc          <= '0;
      oe_reg       <= 1'b0;
      wr_hi        <= '0;
      wr_hi_vld    <= 1'b0;
      hi_on_bus    <= 1'b0;
      pending_qpi  <= 1'b0;
      pending_exit <= 1'b0;
      if (pending_qpi) begin
        qpi_mode <= 1'b1;
      end else if (pending_exit) begin
        qpi_mode <= 1'b0;
      end
    end else begin
      cyc <= (&cyc) ? cyc : cyc + 1'b1;
      case (state)
        ST_IDLE: begin
          if (qpi_mode) begin
            cmd_sr <= {cmd_sr[2:0], sio_in};
          end else begin
            cmd_sr <= {cmd_sr[5:0], sio_in[0]};
          end
          state <= ST_CMD;
        end
        ST_CMD: begin
          if (!qpi_mode) begin
            cmd_sr <= {cmd_sr[5:0], sio_in[0]};
            if (cyc == CYC_SPI_CMD_LAST) begin
              if (spi_cmd == CMD_ENTER_QPI) begin
                pending_qpi <= 1'b1;
              end
              state <= ST_IGNORE;
            end
          end else begin
            cmd_sr <= {cmd_sr[2:0], sio_in};
            case (qpi_cmd)
              CMD_QUAD_READ: begin
                is_read <= 1'b1;
                state   <= ST_ADDR;
              end
              CMD_QUAD_WRITE: begin
                is_read <= 1'b0;
                state   <= ST_ADDR;
              end
              CMD_EXIT_QPI: begin
                pending_exit <= 1'b1;
                state        <= ST_IGNORE;
              end
              default: state <= ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          // Shifting all 24 frame bits through leaves only the low ADDR_BITS.
          addr <= ADDR_BITS'({addr, sio_in});
          if (cyc == CYC_ADDR_LAST) begin
            state <= is_read ? ST_WAIT : ST_WR_DATA;
          end
        end
        ST_WAIT: begin
          if (cyc == CYC_WAIT_LAST) begin
            sio_out   <= arr_rdata[7:4];
            oe_reg    <= 1'b1;
            hi_on_bus <= 1'b1;
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (hi_on_bus) begin
            sio_out   <= arr_rdata[3:0];
            addr      <= addr + ADDR_BITS'(1);
            hi_on_bus <= 1'b0;
          end else begin
            sio_out   <= arr_rdata[7:4];
            hi_on_bus <= 1'b1;
          end
        end
        ST_WR_DATA: begin
          if (wr_hi_vld) begin
            addr      <= addr + ADDR_BITS'(1);
            wr_hi_vld <= 1'b0;
          end else begin
            wr_hi     <= sio_in;
            wr_hi_vld <= 1'b1;
          end
        end
        ST_IGNORE: begin
          state <= ST_IGNORE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for the PSRAM QPI responder: transaction table plus
// hand-written sequences for mode switching, aborts and reset.
module tb_psram_qpi_responder;
  import psram_pkg::*;

  localparam int ADDR_BITS   = 12;
  localparam int WAIT_CYCLES = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out;
  logic       sio_oe;
  logic       qpi_mode;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [23:0] addr;
    int          n;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } txn_t;

  txn_t tbl[8];

  always #5 clk = ~clk;

  psram_qpi_responder #(
    .ADDR_BITS  (ADDR_BITS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_n    (cs_n),
    .sio_in  (sio_in),
    .sio_out (sio_out),
    .sio_oe  (sio_oe),
    .qpi_mode(qpi_mode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cs_high();
    cs_n   = 1'b1;
    sio_in = 4'h0;
    clk_edge();
  endtask

  task automatic send_nib(input logic [3:0] nib);
    cs_n   = 1'b0;
    sio_in = nib;
    clk_edge();
  endtask

  task automatic spi_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) begin
      send_nib({3'b000, c[i]});
    end
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [23:0] a);
    send_nib(c[7:4]);
    send_nib(c[3:0]);
    for (int i = 5; i >= 0; i--) begin
      send_nib(a[i*4 +: 4]);
    end
  endtask

  task automatic qpi_write(input logic [23:0] a, input int n, input logic [7:0] b0, input logic [7:0] b1);
    send_hdr(CMD_QUAD_WRITE, a);
    send_nib(b0[7:4]);
    send_nib(b0[3:0]);
    if (n > 1) begin
      send_nib(b1[7:4]);
      send_nib(b1[3:0]);
    end
    cs_high();
  endtask

  // Header, then wait cycles 8..12 with no output, then data from the edge of cycle 13.
  task automatic qpi_read(input string name, input logic [23:0] a, input int n,
                          input logic [7:0] e0, input logic [7:0] e1);
    logic       early;
    logic [7:0] g0;
    logic [7:0] g1;
    g1 = 8'h00;
    send_hdr(CMD_QUAD_READ, a);
    early = 1'b0;
    for (int i = 0; i < WAIT_CYCLES - 1; i++) begin
      send_nib(4'h0);
      if (sio_oe !== 1'b0) early = 1'b1;
    end
    check({name, "_wait_oe"}, early, 0);
    send_nib(4'h0);
    check({name, "_oe_rise"}, sio_oe, 1);
    g0[7:4] = sio_out;
    send_nib(4'h0);
    g0[3:0] = sio_out;
    if (n > 1) begin
      send_nib(4'h0);
      g1[7:4] = sio_out;
      send_nib(4'h0);
      g1[3:0] = sio_out;
    end
    check({name, "_byte0"}, g0, e0);
    if (n > 1) check({name, "_byte1"}, g1, e1);
    cs_high();
  endtask

  initial begin
    logic seen_oe;

    tbl[0] = '{"wr_10",     1'b1, 24'h000010, 2, 8'hA5, 8'h3C};
    tbl[1] = '{"rd_10",     1'b0, 24'h000010, 2, 8'hA5, 8'h3C};
    tbl[2] = '{"wr_fff",    1'b1, 24'h000FFF, 2, 8'h11, 8'h22};
    tbl[3] = '{"rd_fff",    1'b0, 24'h000FFF, 2, 8'h11, 8'h22};
    tbl[4] = '{"rd_hi_fff", 1'b0, 24'h5A3FFF, 2, 8'h11, 8'h22};
    tbl[5] = '{"rd_000",    1'b0, 24'h000000, 1, 8'h22, 8'h00};
    tbl[6] = '{"wr_456",    1'b1, 24'h123456, 2, 8'hF0, 8'h0F};
    tbl[7] = '{"rd_456",    1'b0, 24'h000456, 2, 8'hF0, 8'h0F};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", sio_oe, 0);
    check("rst_qpi", qpi_mode, 0);
    check("rst_out", sio_out, 0);
    reset = 1'b1;
    cs_high();
    cs_high();
    check("idle_oe", sio_oe, 0);
    check("idle_qpi", qpi_mode, 0);

    // SPI enter-QPI: mode changes only on the following cs_n=1 edge
    spi_cmd(CMD_ENTER_QPI);
    check("spi_qpi_in_frame", qpi_mode, 0);
    cs_n = 1'b1;
    #1;
    check("spi_qpi_before_edge", qpi_mode, 0);
    clk_edge();
    check("spi_qpi_after_edge", qpi_mode, 1);

    // Transaction table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) qpi_write(tbl[i].addr, tbl[i].n, tbl[i].b0, tbl[i].b1);
      else           qpi_read(tbl[i].name, tbl[i].addr, tbl[i].n, tbl[i].b0, tbl[i].b1);
    end

    // Abort after a single write nibble leaves the old byte intact
    qpi_write(24'h000020, 1, 8'h96, 8'h00);
    send_hdr(CMD_QUAD_WRITE, 24'h000020);
    send_nib(4'h7);
    cs_high();
    qpi_read("rd_abort", 24'h000020, 1, 8'h96, 8'h00);

    // sio_oe falls with cs_n, no clock edge needed
    send_hdr(CMD_QUAD_READ, 24'h000020);
    repeat (WAIT_CYCLES) send_nib(4'h0);
    check("drop_oe_before", sio_oe, 1);
    check("drop_hi_nib", sio_out, 4'h9);
    cs_n = 1'b1;
    #1;
    check("drop_oe_after", sio_oe, 0);
    clk_edge();

    // Exit QPI, then a QPI-style read frame must produce nothing
    send_nib(4'hF);
    send_nib(4'h5);
    cs_n = 1'b1;
    #1;
    check("exit_qpi_before_edge", qpi_mode, 1);
    clk_edge();
    check("exit_qpi_after_edge", qpi_mode, 0);
    seen_oe = 1'b0;
    send_hdr(CMD_QUAD_READ, 24'h000010);
    for (int i = 0; i < WAIT_CYCLES + 4; i++) begin
      send_nib(4'h0);
      if (sio_oe !== 1'b0) seen_oe = 1'b1;
    end
    check("spi_eb_no_oe", seen_oe, 0);
    cs_high();
    check("spi_eb_still_spi", qpi_mode, 0);

    // Reset during a read drops the output at once
    spi_cmd(CMD_ENTER_QPI);
    cs_high();
    check("reenter_qpi", qpi_mode, 1);
    send_hdr(CMD_QUAD_READ, 24'h000010);
    repeat (WAIT_CYCLES) send_nib(4'h0);
    check("rstmid_oe_before", sio_oe, 1);
    check("rstmid_hi_nib", sio_out, 4'hA);
    reset = 1'b0;
    #1;
    check("rstmid_oe_after", sio_oe, 0);
    check("rstmid_qpi_after", qpi_mode, 0);
    check("rstmid_out_after", sio_out, 0);
    clk_edge();
    reset = 1'b1;
    cs_high();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
